pre_neuron_state_update: RTL and testbench

PRE_NEURON_STATE_UPDATE -- requirements
Module: pre_neuron_state_update

---
 rtl/pre_neuron_state_update.sv | 144 ++++++++++++++
 tb/tb_pre_neuron_state_update.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_neuron_state_update.sv
// Per-timestep neuron state scan: read each state word, apply leak, integrate and fire,
// write it back, and hand firing neuron indices downstream over a valid/ready port.
module pre_neuron_state_update #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int N_NEURON   = 256
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N_NEURON-1:0]   spk_in,
   input  logic [15:0]           in_weight,
   input  logic [15:0]           threshold,
   input  logic [3:0]            leak_shift,
   input  logic [15:0]           trace_inc,
   output logic                  sram_cs,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q,
   output logic                  spk_valid,
   output logic [ADDR_WIDTH-1:0] spk_addr,
   input  logic                  spk_ready,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, EMIT, FIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] idx;
   logic [N_NEURON-1:0]   spk_l;
   logic [15:0]           wgt_l, thr_l, inc_l;
   logic [3:0]            ls_l;
   logic                  fire_r;

   logic [15:0]           v, t, vl, tl, vsat, tfire, vnew, tnew;
   logic [16:0]           vsum, tsum;
   logic                  fire, last, adv;
   logic [DATA_WIDTH-1:0] wdata;

   // Neuron update, evaluated in CALC while sram_q holds the word read in READ
   always_comb begin
      v     = sram_q[15:0];
      t     = sram_q[31:16];
      vl    = v - (v >> ls_l);
      tl    = t - (t >> ls_l);
      vsum  = {1'b0, vl} + (spk_l[idx] ? {1'b0, wgt_l} : 17'd0);
      vsat  = vsum[16] ? 16'hFFFF : vsum[15:0];
      fire  = (thr_l != 16'd0) && (vsat >= thr_l);
      tsum  = {1'b0, t} + {1'b0, inc_l};
      tfire = tsum[16] ? 16'hFFFF : tsum[15:0];
      vnew  = fire ? 16'd0 : vsat;
      tnew  = fire ? tfire : tl;
      wdata = '0;
      wdata[31:0] = {tnew, vnew};
   end

   assign last = (idx == ADDR_WIDTH'(N_NEURON - 1));
   // Step to the next neuron: after a non-firing write, or when the spike is accepted
   assign adv  = ((state == WRITE) && !fire_r) || ((state == EMIT) && spk_ready);

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         spk_l     <= '0;
         wgt_l     <= '0;
         thr_l     <= '0;
         inc_l     <= '0;
         ls_l      <= '0;
         fire_r    <= 1'b0;
         sram_cs   <= 1'b0;
         sram_we   <= 1'b0;
         sram_a    <= '0;
         sram_d    <= '0;
         spk_valid <= 1'b0;
         spk_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               spk_l   <= spk_in;
               wgt_l   <= in_weight;
               thr_l   <= threshold;
               ls_l    <= leak_shift;
               inc_l   <= trace_inc;
               idx     <= '0;
               state   <= READ;
               busy    <= 1'b1;
               sram_cs <= 1'b1;
               sram_we <= 1'b0;
               sram_a  <= '0;
            end
            READ: begin
               state   <= CALC;
               sram_cs <= 1'b0;
            end
            CALC: begin
               state   <= WRITE;
               fire_r  <= fire;
               sram_cs <= 1'b1;
               sram_we <= 1'b1;
               sram_a  <= idx;
               sram_d  <= wdata;
            end
            WRITE: begin
               sram_cs <= 1'b0;
               sram_we <= 1'b0;
               if (fire_r) begin
                  state     <= EMIT;
                  spk_valid <= 1'b1;
                  spk_addr  <= idx;
               end
            end
            EMIT: ;
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         if (adv) begin
            spk_valid <= 1'b0;
            if (last) begin
               state   <= FIN;
               done    <= 1'b1;
               sram_cs <= 1'b0;
               sram_we <= 1'b0;
            end else begin
               state   <= READ;
               idx     <= idx + 1'b1;
               sram_cs <= 1'b1;
               sram_we <= 1'b0;
               sram_a  <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pre_neuron_state_update.sv
// Bench for pre_neuron_state_update: behavioural SRAM, per-word arithmetic reference,
// spike-order scoreboard and cycle accounting over several randomized scans.
module tb_pre_neuron_state_update;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int N  = 256;

   logic          ck = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [N-1:0]  spk_in = '0;
   logic [15:0]   in_weight = '0, threshold = '0, trace_inc = '0;
   logic [3:0]    leak_shift = '0;
   logic          spk_ready = 1'b0;
   logic          sram_cs, sram_we, spk_valid, busy, done;
   logic [AW-1:0] sram_a, spk_addr;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q = '0;

   int checks = 0, failures = 0;

   pre_neuron_state_update #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_NEURON(N)) dut (
      .ck(ck), .rst(rst), .start(start), .spk_in(spk_in), .in_weight(in_weight),
      .threshold(threshold), .leak_shift(leak_shift), .trace_inc(trace_inc),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d),
      .sram_q(sram_q), .spk_valid(spk_valid), .spk_addr(spk_addr),
      .spk_ready(spk_ready), .busy(busy), .done(done)
   );

   always #5 ck = ~ck;

   // behavioural state SRAM with access counters
   logic [DW-1:0] mem [N];
   logic [DW-1:0] pre_mem [N];
   int            rd_cnt [N];
   int            wr_cnt [N];
   bit            load_req = 1'b0, clr_req = 1'b0;

   always @(posedge ck) begin
      if (load_req)
         for (int i = 0; i < N; i++) mem[i] <= pre_mem[i];
      if (clr_req) begin
         for (int i = 0; i < N; i++) begin
            rd_cnt[i] <= 0;
            wr_cnt[i] <= 0;
         end
      end else if (sram_cs) begin
         if (sram_we) begin
            mem[sram_a]    <= sram_d;
            wr_cnt[sram_a] <= wr_cnt[sram_a] + 1;
         end else begin
            sram_q         <= mem[sram_a];
            rd_cnt[sram_a] <= rd_cnt[sram_a] + 1;
         end
      end
   end

   logic [31:0] exp_mem [N];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference: one neuron's timestep, in plain integer arithmetic; bit 32 = fired
   function automatic logic [32:0] upd(input logic [31:0] w, input bit s, input int iw,
                                       input int th, input int ls, input int inc);
      int v, t, vn, tn;
      bit f;
      v  = int'(w[15:0]);
      t  = int'(w[31:16]);
      vn = v - (v >> ls);
      if (s) vn = vn + iw;
      if (vn > 65535) vn = 65535;
      f = (th != 0) && (vn >= th);
      if (f) begin
         vn = 0;
         tn = (t + inc > 65535) ? 65535 : t + inc;
      end else begin
         tn = t - (t >> ls);
      end
      return {f, tn[15:0], vn[15:0]};
   endfunction

   task automatic load_mem();
      for (int i = 0; i < N; i++) pre_mem[i] = exp_mem[i];
      @(negedge ck) load_req = 1'b1;
      @(negedge ck) load_req = 1'b0;
   endtask

   task automatic rand_spk();
      for (int i = 0; i < N; i++) spk_in[i] = 1'($urandom_range(0, 1));
   endtask

   // mode 0: random ready, 1: ready always high, 2: first spike held 10 cycles
   task automatic run_scan(input int mode, input bit mid_start,
                           output int first_len, output int first_addr,
                           output int nspk, output int done_n);
      logic [32:0] r;
      int exp_q[$], got_q[$];
      int n, e, cur_len, sno, bad;
      bit prev_v, prev_r, rdy, seen;
      logic [AW-1:0] prev_a;
      for (int i = 0; i < N; i++) begin
         r = upd(exp_mem[i], spk_in[i], int'(in_weight), int'(threshold),
                 int'(leak_shift), int'(trace_inc));
         exp_mem[i] = r[31:0];
         if (r[32]) exp_q.push_back(i);
      end
      first_len = 0; first_addr = -1; done_n = 0;
      e = 0; cur_len = 0; sno = 0; prev_v = 0; prev_r = 0; prev_a = '0; seen = 0;
      @(negedge ck) clr_req = 1'b1;
      @(negedge ck) begin clr_req = 1'b0; start = 1'b1; end
      @(negedge ck) start = 1'b0;
      n = 1;
      while (!seen && n < 20000) begin
         if (n == 1) begin
            chk("busy_on", busy, 1'b1);
            chk("first_read", {sram_cs, sram_we, sram_a}, {1'b1, 1'b0, 8'd0});
         end
         if (n == 3) chk("first_write", {sram_cs, sram_we, sram_a}, {1'b1, 1'b1, 8'd0});
         if (prev_v) chk("valid_hold", spk_valid, !prev_r);
         if (prev_v && !prev_r) chk("addr_hold", spk_addr, prev_a);
         if (prev_v && prev_r && prev_a != AW'(N - 1))
            chk("next_read", {sram_cs, sram_we, sram_a}, {1'b1, 1'b0, prev_a + 8'd1});
         if (spk_valid) begin
            e++;
            cur_len++;
            if (mode == 2 && sno == 0) rdy = (cur_len >= 11);
            else if (mode == 1)        rdy = 1'b1;
            else                       rdy = 1'($urandom_range(0, 1));
            if (rdy) begin
               got_q.push_back(int'(spk_addr));
               if (sno == 0) begin first_len = cur_len; first_addr = int'(spk_addr); end
               sno++;
               cur_len = 0;
            end
         end else begin
            rdy = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         spk_ready = rdy;
         prev_v = spk_valid; prev_r = rdy; prev_a = spk_addr;
         if (mid_start && n == 100) begin
            start = 1'b1; threshold = 16'h0001; in_weight = 16'hFFFF; spk_in = '1;
         end
         if (mid_start && n == 101) start = 1'b0;
         if (done) begin
            seen = 1'b1;
            done_n = n;
            chk("done_time", n, 1 + 3 * N + e);
            @(negedge ck);
            chk("done_pulse", done, 1'b0);
            chk("busy_off", busy, 1'b0);
         end else begin
            @(negedge ck);
            n++;
         end
      end
      chk("done_seen", seen, 1'b1);
      nspk = got_q.size();
      chk("spk_cnt", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk("spk_order", got_q[i], exp_q[i]);
      bad = 0;
      for (int i = 0; i < N; i++) if (rd_cnt[i] != 1 || wr_cnt[i] != 1) bad++;
      chk("rw_once", bad, 0);
      for (int i = 0; i < N; i++) chk($sformatf("mem[%0d]", i), mem[i], exp_mem[i]);
   endtask

   initial begin
      int fl, fa, ns, dn, n;
      logic [32:0] r;
      bit found;

      repeat (2) @(negedge ck);
      chk("rst_outs", {sram_cs, sram_we, sram_a, sram_d, spk_valid, spk_addr, busy, done}, '0);
      rst = 1'b0;
      repeat (2) @(negedge ck);
      chk("idle_wait", busy, 1'b0);

      // leak only on word 0
      for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
      exp_mem[0] = 32'h0100_0040;
      load_mem();
      rand_spk(); spk_in[0] = 1'b0;
      leak_shift = 4'd2; threshold = 16'h1000; in_weight = 16'h0200; trace_inc = 16'h0100;
      run_scan(0, 1'b0, fl, fa, ns, dn);
      chk("leak_word0", mem[0], 32'h00C0_0030);

      // fire on word 5 with saturating trace, downstream stalls 10 cycles
      for (int i = 0; i < N; i++) exp_mem[i] = {16'($urandom), 16'($urandom_range(0, 16'h07FF))};
      exp_mem[5] = 32'hFFF0_0F00;
      load_mem();
      spk_in = '0; spk_in[5] = 1'b1;
      leak_shift = 4'd15; threshold = 16'h1000; in_weight = 16'h0200; trace_inc = 16'h0100;
      run_scan(2, 1'b0, fl, fa, ns, dn);
      chk("fire_word5", mem[5], 32'hFFFF_0000);
      chk("fire_addr", fa, 5);
      chk("hold_len", fl, 11);

      // quiet scan timing with a stray START mid-scan
      for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
      load_mem();
      spk_in = '0; threshold = 16'hFFFF; leak_shift = 4'($urandom_range(0, 15));
      in_weight = 16'h1234; trace_inc = 16'h0010;
      run_scan(1, 1'b1, fl, fa, ns, dn);
      chk("scan_768", dn - 1, 768);
      chk("quiet_nospk", ns, 0);

      // saturation with threshold 0 never fires
      for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
      exp_mem[3] = {16'($urandom), 16'hFFF0};
      load_mem();
      rand_spk(); spk_in[3] = 1'b1;
      in_weight = 16'h0100; threshold = 16'h0000; leak_shift = 4'd15; trace_inc = 16'h0055;
      run_scan(0, 1'b0, fl, fa, ns, dn);
      chk("sat_v", mem[3][15:0], 16'hFFFF);
      chk("thr0_nospk", ns, 0);

      // fully random scans
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
         load_mem();
         rand_spk();
         in_weight = 16'($urandom_range(0, 16'h2000));
         threshold = 16'($urandom_range(16'h0800, 16'h4000));
         leak_shift = 4'($urandom_range(0, 15));
         trace_inc = 16'($urandom);
         run_scan(0, 1'b0, fl, fa, ns, dn);
      end

      // reset during CALC of neuron 7
      for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
      load_mem();
      rand_spk();
      in_weight = 16'h0300; threshold = 16'h0000; leak_shift = 4'd3; trace_inc = 16'h0001;
      for (int i = 0; i < 7; i++) begin
         r = upd(exp_mem[i], spk_in[i], int'(in_weight), 0, 3, 1);
         exp_mem[i] = r[31:0];
      end
      @(negedge ck) clr_req = 1'b1;
      @(negedge ck) begin clr_req = 1'b0; start = 1'b1; end
      @(negedge ck) start = 1'b0;
      found = 1'b0; n = 0;
      while (!found && n < 100) begin
         if (sram_cs && !sram_we && sram_a == 8'd7) found = 1'b1;
         else begin @(negedge ck); n++; end
      end
      chk("reach_read7", found, 1'b1);
      @(negedge ck) rst = 1'b1;
      #1;
      chk("rst_mid_outs", {sram_cs, sram_we, sram_a, sram_d, spk_valid, spk_addr, busy, done}, '0);
      repeat (2) @(negedge ck);
      rst = 1'b0;
      repeat (3) begin
         @(negedge ck);
         chk("post_rst_idle", {busy, sram_cs}, 2'b00);
      end
      chk("no_write7", wr_cnt[7], 0);
      for (int i = 0; i < N; i++) chk($sformatf("abort_mem[%0d]", i), mem[i], exp_mem[i]);
      run_scan(0, 1'b0, fl, fa, ns, dn);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
